// File: rtl/prog_boolexp.sv
// Programmable N_IN-input Boolean function unit: serially loaded truth table, registered evaluation.
// Optional macro PROG_BOOLEXP_POPCNT_EN adds a popcnt output (number of 1s in the committed table).
module prog_boolexp #(
    parameter int                    N_IN              = 3,
    parameter logic [(1<<N_IN)-1:0]  RESET_TT          = '0,
    parameter bit                    TT_VALID_AT_RESET = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_start,
    input  logic            cfg_bit_valid,
    input  logic            cfg_bit,
    output logic            cfg_busy,
    output logic            cfg_done,
    input  logic            in_valid,
    input  logic [N_IN-1:0] x,
    output logic            y,
    output logic            out_valid,
    output logic            err
`ifdef PROG_BOOLEXP_POPCNT_EN
    ,
    output logic [N_IN:0]   popcnt
`endif
);

    localparam int T = 1 << N_IN;

    function automatic logic [N_IN:0] count_ones(input logic [T-1:0] v);
        logic [N_IN:0] c;
        c = '0;
        for (int i = 0; i < T; i++) begin
            c = c + (N_IN+1)'(v[i]);
        end
        return c;
    endfunction

    localparam logic [N_IN:0] LAST_IDX  = (N_IN+1)'(T - 1);
    localparam logic [N_IN:0] RESET_POP = count_ones(RESET_TT);

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t          state_q;
    logic [N_IN:0]   cnt_q;
    logic [T-1:0]    shadow_q;
    logic [T-1:0]    shadow_d;
    logic [T-1:0]    tbl_q;
    logic            tbl_valid_q;
    logic            cfg_busy_q;
    logic            cfg_done_q;
    logic            y_q;
    logic            out_valid_q;
    logic            err_q;
    logic [N_IN-1:0] wr_idx;
`ifdef PROG_BOOLEXP_POPCNT_EN
    logic [N_IN:0]   pop_acc_q;
    logic [N_IN:0]   popcnt_q;
`endif

    assign wr_idx = cnt_q[N_IN-1:0];

    // Shadow with the incoming bit merged, so the final bit can be committed in the same edge.
    always_comb begin
        shadow_d         = shadow_q;
        shadow_d[wr_idx] = cfg_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shadow_q    <= '0;
            tbl_q       <= RESET_TT;
            tbl_valid_q <= TT_VALID_AT_RESET;
            cfg_busy_q  <= 1'b0;
            cfg_done_q  <= 1'b0;
`ifdef PROG_BOOLEXP_POPCNT_EN
            pop_acc_q   <= '0;
            popcnt_q    <= RESET_POP;
`endif
        end else begin
            cfg_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cfg_start) begin
                        state_q    <= LOAD;
                        cnt_q      <= '0;
                        shadow_q   <= '0;
                        cfg_busy_q <= 1'b1;
`ifdef PROG_BOOLEXP_POPCNT_EN
                        pop_acc_q  <= '0;
`endif
                    end
                end
                LOAD: begin
                    if (cfg_start) begin
                        // Restart wins over a bit offered in the same cycle.
                        cnt_q      <= '0;
                        shadow_q   <= '0;
`ifdef PROG_BOOLEXP_POPCNT_EN
                        pop_acc_q  <= '0;
`endif
                    end else if (cfg_bit_valid) begin
                        if (cnt_q == LAST_IDX) begin
                            tbl_q       <= shadow_d;
                            tbl_valid_q <= 1'b1;
                            cfg_done_q  <= 1'b1;
                            cfg_busy_q  <= 1'b0;
                            state_q     <= IDLE;
`ifdef PROG_BOOLEXP_POPCNT_EN
                            popcnt_q    <= pop_acc_q + (N_IN+1)'(cfg_bit);
`endif
                        end else begin
                            shadow_q  <= shadow_d;
                            cnt_q     <= cnt_q + 1'b1;
`ifdef PROG_BOOLEXP_POPCNT_EN
                            pop_acc_q <= pop_acc_q + (N_IN+1)'(cfg_bit);
`endif
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    cfg_busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Evaluation only ever sees the committed table; a commit on the same edge is not yet visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q         <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                if (tbl_valid_q) begin
                    y_q   <= tbl_q[x];
                    err_q <= 1'b0;
                end else begin
                    y_q   <= 1'b0;
                    err_q <= 1'b1;
                end
            end else begin
                err_q <= 1'b0;
            end
        end
    end

    assign cfg_busy  = cfg_busy_q;
    assign cfg_done  = cfg_done_q;
    assign y         = y_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;
`ifdef PROG_BOOLEXP_POPCNT_EN
    assign popcnt    = popcnt_q;
`endif

endmodule

// File: tb/tb_prog_boolexp.sv
// Self-checking bench for prog_boolexp (N_IN=3): vector table, directed load sequences, random traffic.
module tb_prog_boolexp;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_start, cfg_bit_valid, cfg_bit;
    logic       cfg_busy, cfg_done;
    logic       in_valid;
    logic [2:0] x;
    logic       y, out_valid, err;
`ifdef PROG_BOOLEXP_POPCNT_EN
    logic [3:0] popcnt;
`endif

    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    // Reference model: committed table, load progress and expected outputs
    logic [7:0] m_tbl;
    logic       m_valid;
    logic       m_loading;
    int         m_cnt;
    logic [7:0] m_shadow;
    logic       e_y, e_ov, e_err, e_done;

    prog_boolexp dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_start(cfg_start), .cfg_bit_valid(cfg_bit_valid), .cfg_bit(cfg_bit),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done),
        .in_valid(in_valid), .x(x),
        .y(y), .out_valid(out_valid), .err(err)
`ifdef PROG_BOOLEXP_POPCNT_EN
        , .popcnt(popcnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_tbl = 8'h00; m_valid = 1'b0; m_loading = 1'b0; m_cnt = 0; m_shadow = 8'h00;
        e_y = 1'b0; e_ov = 1'b0; e_err = 1'b0; e_done = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
        chk({tag, ".y"},         32'(y),         32'(e_y));
        chk({tag, ".err"},       32'(err),       32'(e_err));
        chk({tag, ".cfg_done"},  32'(cfg_done),  32'(e_done));
        chk({tag, ".cfg_busy"},  32'(cfg_busy),  32'(m_loading));
`ifdef PROG_BOOLEXP_POPCNT_EN
        chk({tag, ".popcnt"},    32'(popcnt),    32'($countones(m_tbl)));
`endif
    endtask

    // One clock: drive inputs, advance the model across the edge, check all outputs.
    task automatic cyc(input string tag, input logic st, input logic bv, input logic b,
                       input logic iv, input logic [2:0] xx);
        cfg_start = st; cfg_bit_valid = bv; cfg_bit = b; in_valid = iv; x = xx;
        @(posedge clk);
        e_ov = iv;
        if (iv) begin
            e_y   = m_valid ? m_tbl[xx] : 1'b0;
            e_err = !m_valid;
        end else begin
            e_err = 1'b0;
        end
        e_done = 1'b0;
        if (st) begin
            m_loading = 1'b1; m_cnt = 0; m_shadow = 8'h00;
        end else if (m_loading && bv) begin
            m_shadow[m_cnt] = b;
            m_cnt++;
            if (m_cnt == 8) begin
                m_tbl = m_shadow; m_valid = 1'b1; m_loading = 1'b0; e_done = 1'b1;
            end
        end
        #1;
        if (cfg_done === 1'b1) done_seen++;
        check_all(tag);
        cfg_start = 1'b0; cfg_bit_valid = 1'b0; in_valid = 1'b0;
    endtask

    task automatic load_table(input string tag, input logic [7:0] v);
        cyc(tag, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 8; i++) cyc(tag, 1'b0, 1'b1, v[i], 1'b0, 3'd0);
    endtask

    typedef struct {
        logic [2:0] x;
        logic       exp_y;
        logic       exp_err;
    } vec_t;

    vec_t vecs[10];

    initial begin
        // Expected results for table 8'h96 (minterms 1,2,4,7 true)
        vecs[0] = '{3'b011, 1'b0, 1'b0};
        vecs[1] = '{3'b111, 1'b1, 1'b0};
        vecs[2] = '{3'b001, 1'b1, 1'b0};
        vecs[3] = '{3'b000, 1'b0, 1'b0};
        vecs[4] = '{3'b010, 1'b1, 1'b0};
        vecs[5] = '{3'b100, 1'b1, 1'b0};
        vecs[6] = '{3'b101, 1'b0, 1'b0};
        vecs[7] = '{3'b110, 1'b0, 1'b0};
        vecs[8] = '{3'b111, 1'b1, 1'b0};
        vecs[9] = '{3'b000, 1'b0, 1'b0};

        rst_n = 1'b0; cfg_start = 1'b0; cfg_bit_valid = 1'b0; cfg_bit = 1'b0;
        in_valid = 1'b0; x = 3'd0;
        model_reset();
        #12;
        check_all("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: evaluation before any load reports err
        cyc("t1", 1'b0, 1'b0, 1'b0, 1'b1, 3'b101);
        chk("t1.err_direct", 32'(err), 32'd1);

        // 2: load 8'h96, then back-to-back vector table
        done_seen = 0;
        load_table("t2", 8'h96);
        chk("t2.done_count", 32'(done_seen), 32'd1);
        for (int i = 0; i < 10; i++) begin
            cyc("t2v", 1'b0, 1'b0, 1'b0, 1'b1, vecs[i].x);
            chk("t2v.y_table",   32'(y),   32'(vecs[i].exp_y));
            chk("t2v.err_table", 32'(err), 32'(vecs[i].exp_err));
        end
        cyc("t2idle", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        chk("t2idle.y_hold", 32'(y), 32'd0);

        // 3: load 8'hFF with stalls; old table used mid-load and on the commit cycle
        cyc("t3", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 8; i++) begin
            if (i == 2 || i == 4 || i == 5) cyc("t3stall", 1'b0, 1'b0, 1'b0, (i == 4), 3'b000);
            if (i == 4) chk("t3.mid_old", 32'(y), 32'd0);
            cyc("t3", 1'b0, 1'b1, 1'b1, (i == 7), 3'b000);
        end
        chk("t3.commit_old", 32'(y), 32'd0);
        chk("t3.done", 32'(cfg_done), 32'd1);
        cyc("t3eval", 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
        chk("t3.new", 32'(y), 32'd1);

        // 4: restart after 5 bits, then 8'h80
        done_seen = 0;
        cyc("t4", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 5; i++) cyc("t4part", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        cyc("t4restart", 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        for (int i = 0; i < 8; i++) cyc("t4", 1'b0, 1'b1, (i == 7), 1'b0, 3'd0);
        chk("t4.done_count", 32'(done_seen), 32'd1);
        for (int i = 0; i < 8; i++) begin
            cyc("t4eval", 1'b0, 1'b0, 1'b0, 1'b1, 3'(i));
            chk("t4.y_80", 32'(y), 32'(i == 7));
        end
        // cfg_bit_valid in IDLE must not disturb anything
        cyc("t4idlebit", 1'b0, 1'b1, 1'b1, 1'b1, 3'b000);

`ifdef PROG_BOOLEXP_POPCNT_EN
        // 6: popcount visible in the cfg_done cycle
        load_table("t6", 8'h96);
        chk("t6.pop96", 32'(popcnt), 32'd4);
        load_table("t6", 8'h00);
        chk("t6.pop00", 32'(popcnt), 32'd0);
`endif

        // 5: asynchronous reset mid-load
        cyc("t5", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 4; i++) cyc("t5", 1'b0, 1'b1, 1'b1, (i == 3), 3'b111);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("t5rst");
        @(posedge clk); #1;
        check_all("t5rst_hold");
        rst_n = 1'b1;
        cyc("t5eval", 1'b0, 1'b0, 1'b0, 1'b1, 3'b111);
        chk("t5.err_after", 32'(err), 32'd1);

        // Random traffic: loads with stalls and restarts interleaved with evaluations
        for (int n = 0; n < 600; n++) begin
            cyc("rand", ($urandom_range(0, 29) == 0), ($urandom_range(0, 2) != 0),
                1'($urandom), 1'($urandom), 3'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
